// File: rtl/jk_pkg.sv
// Package: jk_pkg
// Purpose: shared opcode encodings, FSM state type and the JK next-state
//          helper used by the bank sequencer and its flop bank.
// Contents:
//   JK_HOLD/JK_CLR/JK_SET/JK_TGL  2-bit opcodes, bit 1 = J, bit 0 = K
//   state_t                       sequencer FSM states (ST_IDLE, ST_EXEC)
//   jk_next()                     JK flip-flop truth table for one bit
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // Next value of a single JK flop given its present value and J/K inputs.
  function automatic logic jk_next(input logic q_cur, input logic j_in, input logic k_in);
    logic q_nxt;
    case ({j_in, k_in})
      JK_HOLD: q_nxt = q_cur;
      JK_CLR:  q_nxt = 1'b0;
      JK_SET:  q_nxt = 1'b1;
      JK_TGL:  q_nxt = ~q_cur;
      default: q_nxt = q_cur;
    endcase
    return q_nxt;
  endfunction

endpackage

// File: rtl/jk_reg_bank.sv
// Module: jk_reg_bank
// Purpose: WIDTH independent JK flip-flops with synchronous active-high clear.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous clear, active high (q -> 0)
//   j    in   WIDTH  J inputs, one per flop
//   k    in   WIDTH  K inputs, one per flop
//   q    out  WIDTH  registered flop state
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Per-bit JK truth table.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      q_d[i] = jk_next(q_q[i], j[i], k[i]);
    end
  end

  // Flop bank with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Module: jk_bank_sequencer
// Purpose: shares one WIDTH-bit JK bank between N_REQ requesters. A round-robin
//          arbiter picks one request, its opcode/mask/length are latched, and the
//          bank's J/K inputs are driven for max(len,1) edges on the masked bits.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset (aborts any running command)
//   req   in   N_REQ        request level per requester
//   cmd   in   2*N_REQ      opcode per requester, slice r = [2r+1:2r]
//   mask  in   N_REQ*WIDTH  bit enable per requester, slice r = [WIDTH*r +: WIDTH]
//   len   in   N_REQ*LEN_W  edges to apply per requester, 0 behaves as 1
//   gnt   out  N_REQ        one-hot grant, single-cycle pulse
//   busy  out  high while a command executes
//   done  out  single-cycle pulse after the last application edge
//   q     out  WIDTH        JK bank state
module jk_bank_sequencer
  import jk_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     cmd,
  input  logic [N_REQ*WIDTH-1:0] mask,
  input  logic [N_REQ*LEN_W-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       q
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               win_vld_s;
  logic [PTR_W-1:0]   win_idx_s;
  logic [1:0]         win_op_s;
  logic [WIDTH-1:0]   win_mask_s;
  logic [LEN_W-1:0]   win_len_s;
  logic [N_REQ-1:0]   win_onehot_s;
  logic               last_s;
  logic               exec_s;
  logic [WIDTH-1:0]   bank_j_s;
  logic [WIDTH-1:0]   bank_k_s;

  // Round-robin search: first set request at or above ptr, wrapping upward.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      win_idx_s = (!win_vld_s && req[(int'(ptr_q) + i) % N_REQ])
                  ? PTR_W'((int'(ptr_q) + i) % N_REQ) : win_idx_s;
      win_vld_s = win_vld_s | req[(int'(ptr_q) + i) % N_REQ];
    end
  end

  assign win_op_s     = cmd[2*win_idx_s +: 2];
  assign win_mask_s   = mask[WIDTH*win_idx_s +: WIDTH];
  assign win_len_s    = len[LEN_W*win_idx_s +: LEN_W];
  assign win_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
  assign last_s       = (cnt_q == {LEN_W{1'b0}});

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = win_vld_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_d = last_s ? ST_IDLE : ST_EXEC;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead so gnt/busy/done leave flops.
  always_comb begin
    gnt_d  = {N_REQ{1'b0}};
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d  = win_vld_s ? win_onehot_s : {N_REQ{1'b0}};
        busy_d = win_vld_s;
        done_d = 1'b0;
      end
      ST_EXEC: begin
        gnt_d  = {N_REQ{1'b0}};
        busy_d = ~last_s;
        done_d = last_s;
      end
      default: begin
        gnt_d  = {N_REQ{1'b0}};
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Command latch, repeat counter and round-robin pointer update.
  always_comb begin
    op_d   = op_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld_s) begin
          op_d   = win_op_s;
          mask_d = win_mask_s;
          // len = 0 behaves as a single application.
          cnt_d  = (win_len_s == {LEN_W{1'b0}}) ? {LEN_W{1'b0}}
                                                 : win_len_s - {{(LEN_W-1){1'b0}}, 1'b1};
          ptr_d  = (win_idx_s == LAST_IDX) ? {PTR_W{1'b0}}
                                           : win_idx_s + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
          op_d   = op_q;
          mask_d = mask_q;
          cnt_d  = cnt_q;
          ptr_d  = ptr_q;
        end
      end
      ST_EXEC: begin
        cnt_d = last_s ? cnt_q : cnt_q - {{(LEN_W-1){1'b0}}, 1'b1};
      end
      default: begin
        cnt_d = {LEN_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= {PTR_W{1'b0}};
      op_q   <= JK_HOLD;
      mask_q <= {WIDTH{1'b0}};
      cnt_q  <= {LEN_W{1'b0}};
      gnt_q  <= {N_REQ{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      op_q   <= op_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // J/K gating: the latched opcode reaches only masked bits and only in EXEC.
  assign exec_s   = (state_q == ST_EXEC);
  assign bank_j_s = exec_s ? (mask_q & {WIDTH{op_q[1]}}) : {WIDTH{1'b0}};
  assign bank_k_s = exec_s ? (mask_q & {WIDTH{op_q[0]}}) : {WIDTH{1'b0}};

  jk_reg_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk (clk),
    .rst (rst),
    .j   (bank_j_s),
    .k   (bank_k_s),
    .q   (q)
  );

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
module tb_jk_bank_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  cmd;
  logic [31:0] mask;
  logic [15:0] len;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [7:0]  q;

  int errors;
  int checks;

  logic [7:0] sb_q[$];
  logic [7:0] q_model;

  typedef struct {
    int         r;
    logic [1:0] op;
    logic [7:0] msk;
    logic [3:0] ln;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[7];

  jk_bank_sequencer #(
    .N_REQ (4),
    .WIDTH (8),
    .LEN_W (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .cmd  (cmd),
    .mask (mask),
    .len  (len),
    .gnt  (gnt),
    .busy (busy),
    .done (done),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_apply(input logic [7:0] cur, input logic [1:0] op,
                                             input logic [7:0] msk);
    logic [7:0] nxt;
    nxt = cur;
    for (int b = 0; b < 8; b++) begin
      if (msk[b]) begin
        case (op)
          2'b00:   nxt[b] = cur[b];
          2'b01:   nxt[b] = 1'b0;
          2'b10:   nxt[b] = 1'b1;
          default: nxt[b] = ~cur[b];
        endcase
      end
    end
    return nxt;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_model = 8'h00;
  endtask

  // One single-requester command: grant, per-edge q via the scoreboard, done/busy.
  task automatic run_vec(input vec_t v);
    int n;
    int eff;
    logic [7:0] m;
    logic [7:0] e;
    @(negedge clk);
    cmd[2*v.r +: 2]  = v.op;
    mask[8*v.r +: 8] = v.msk;
    len[4*v.r +: 4]  = v.ln;
    req = 4'b0001 << v.r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0000 && n < 8);
    check("vec_gnt", {28'd0, gnt}, {28'd0, 4'b0001 << v.r});
    check("vec_busy_on_grant", {31'd0, busy}, 32'd1);
    req = 4'b0000;
    eff = (v.ln == 4'd0) ? 1 : int'(v.ln);
    m = q_model;
    for (int k = 0; k < eff; k++) begin
      m = model_apply(m, v.op, v.msk);
      sb_q.push_back(m);
    end
    q_model = m;
    for (int k = 0; k < eff; k++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      check("vec_q_edge", {24'd0, q}, {24'd0, e});
      check("vec_done", {31'd0, done}, {31'd0, (k == eff - 1)});
      check("vec_busy", {31'd0, busy}, {31'd0, (k != eff - 1)});
      check("vec_gnt_once", {28'd0, gnt}, 32'd0);
    end
    check("vec_final_q", {24'd0, q}, {24'd0, v.exp_q});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    q_model = 8'h00;

    // r, op, mask, len, expected q after the command
    vecs[0] = '{0, 2'b10, 8'h0F, 4'd1, 8'h0F};  // single SET
    vecs[1] = '{1, 2'b01, 8'hFF, 4'd1, 8'h00};  // clear everything
    vecs[2] = '{2, 2'b11, 8'h81, 4'd3, 8'h81};  // burst toggle 81,00,81
    vecs[3] = '{3, 2'b10, 8'hFF, 4'd2, 8'hFF};  // set all, two edges
    vecs[4] = '{1, 2'b01, 8'hF0, 4'd0, 8'h0F};  // len=0 acts as one CLEAR
    vecs[5] = '{0, 2'b11, 8'h3C, 4'd4, 8'h0F};  // even toggle count: unchanged
    vecs[6] = '{3, 2'b10, 8'h30, 4'd1, 8'h3F};  // partial SET

    // Reset with arbitrary inputs present.
    rst  = 1'b1;
    req  = 4'hF;
    cmd  = 8'hFF;
    mask = 32'hFFFF_FFFF;
    len  = 16'h5555;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_q", {24'd0, q}, 32'd0);
    check("reset_gnt", {28'd0, gnt}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    req = 4'h0;
    cmd = 8'h00;
    mask = 32'd0;
    len = 16'd0;
    rst = 1'b0;
    q_model = 8'h00;

    @(negedge clk);
    check("idle_no_req_gnt", {28'd0, gnt}, 32'd0);
    check("idle_no_req_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
    end

    // Round-robin fairness with all requests held, HOLD opcodes, len=1.
    do_reset();
    cmd  = 8'h00;
    mask = 32'hFFFF_FFFF;
    len  = 16'h1111;
    req  = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("rr_gnt", {28'd0, gnt},
            (c % 2 == 0) ? {28'd0, 4'b0001 << ((c / 2) % 4)} : 32'd0);
      check("rr_done", {31'd0, done}, {31'd0, (c % 2 == 1)});
    end
    req = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check("rr_hold_q", {24'd0, q}, 32'd0);

    // Reset in the middle of a long toggle burst.
    do_reset();
    cmd[3:2]   = 2'b11;
    mask[15:8] = 8'hFF;
    len[7:4]   = 4'd8;
    req = 4'b0010;
    @(negedge clk);
    check("abort_gnt", {28'd0, gnt}, 32'h2);
    req = 4'b0000;
    @(negedge clk);
    check("abort_q_edge1", {24'd0, q}, 32'hFF);
    @(negedge clk);
    check("abort_q_edge2", {24'd0, q}, 32'h00);
    rst = 1'b1;
    @(negedge clk);
    check("abort_q", {24'd0, q}, 32'h00);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);
    check("abort_no_busy", {31'd0, busy}, 32'd0);
    check("abort_no_retry", {28'd0, gnt}, 32'd0);
    // Pointer is back at requester 0, so it beats requester 1.
    cmd[1:0]  = 2'b10;
    mask[7:0] = 8'h5A;
    len[3:0]  = 4'd1;
    cmd[3:2]  = 2'b00;
    req = 4'b0011;
    @(negedge clk);
    check("post_reset_gnt", {28'd0, gnt}, 32'h1);
    req = 4'b0000;
    @(negedge clk);
    check("post_reset_q", {24'd0, q}, 32'h5A);
    check("post_reset_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
